// File: rtl/lenet_run_pkg.sv
// Shared types and width helpers for the LeNet batch-run controller.
package lenet_run_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_START,
        S_WAIT,
        S_DONE,
        S_ERR
    } run_state_e;

    localparam int DEF_MAX_RUNS    = 16;
    localparam int DEF_TIMEOUT_CYC = 3000;

    // Index width never drops below 1 so a single-entry buffer still has an address bit.
    function automatic int idx_w(input int max_runs);
        return (max_runs > 1) ? $clog2(max_runs) : 1;
    endfunction

    function automatic int cnt_w(input int max_runs);
        return $clog2(max_runs + 1);
    endfunction

    localparam int IDX_W = idx_w(DEF_MAX_RUNS);
    localparam int CNT_W = cnt_w(DEF_MAX_RUNS);

endpackage

// File: rtl/lenet_run_ctrl_if.sv
// Start/done handshake between the batch controller (master) and the LeNet accelerator (slave).
interface lenet_run_ctrl_if
    import lenet_run_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int MAX_RUNS   = DEF_MAX_RUNS
) ();

    logic                        start;
    logic [idx_w(MAX_RUNS)-1:0]  img;
    logic                        busy;
    logic                        done;
    logic [DATA_WIDTH-1:0]       result;

    modport master (output start, output img, input busy, input done, input result);
    modport slave  (input start, input img, output busy, output done, output result);

endinterface

// File: rtl/lenet_result_buf.sv
// Per-run result store: one write port, one asynchronous read port, cleared on reset.
module lenet_result_buf
    import lenet_run_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CYC_WIDTH  = 24,
    parameter int MAX_RUNS   = DEF_MAX_RUNS
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        wr_en_i,
    input  logic [idx_w(MAX_RUNS)-1:0]  wr_addr_i,
    input  logic [DATA_WIDTH-1:0]       wr_result_i,
    input  logic [CYC_WIDTH-1:0]        wr_cycles_i,
    input  logic [idx_w(MAX_RUNS)-1:0]  rd_addr_i,
    output logic [DATA_WIDTH-1:0]       rd_result_o,
    output logic [CYC_WIDTH-1:0]        rd_cycles_o
);

    localparam int ENTRY_W = DATA_WIDTH + CYC_WIDTH;

    logic [ENTRY_W-1:0] mem_q [MAX_RUNS];
    logic [ENTRY_W-1:0] rd_entry;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MAX_RUNS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en_i) begin
            mem_q[wr_addr_i] <= {wr_result_i, wr_cycles_i};
        end
    end

    assign rd_entry                   = mem_q[rd_addr_i];
    assign {rd_result_o, rd_cycles_o} = rd_entry;

endmodule

// File: rtl/lenet_run_ctrl.sv
// Batch-run controller: pulses the accelerator start for each image, watches done under a
// cycle watchdog, and records each result with its latency.
module lenet_run_ctrl
    import lenet_run_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int MAX_RUNS    = DEF_MAX_RUNS,
    parameter int CYC_WIDTH   = 24,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    parameter int SETTLE_CYC  = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        go_i,
    input  logic [cnt_w(MAX_RUNS)-1:0]  num_runs_i,
    output logic                        busy_o,
    output logic                        finished_o,
    output logic                        timeout_err_o,
    output logic [idx_w(MAX_RUNS)-1:0]  err_run_o,
    input  logic [idx_w(MAX_RUNS)-1:0]  rd_addr_i,
    output logic [DATA_WIDTH-1:0]       rd_result_o,
    output logic [CYC_WIDTH-1:0]        rd_cycles_o,
    lenet_run_ctrl_if.master            acc
);

    localparam int IDX_W = idx_w(MAX_RUNS);
    localparam int CNT_W = cnt_w(MAX_RUNS);

    localparam logic [CNT_W-1:0]     MAX_RUNS_C   = CNT_W'(MAX_RUNS);
    localparam logic [CYC_WIDTH-1:0] TIMEOUT_LAST = CYC_WIDTH'(TIMEOUT_CYC - 1);
    localparam logic [CYC_WIDTH-1:0] SETTLE_LAST  = CYC_WIDTH'(SETTLE_CYC - 1);

    run_state_e           state_q;
    logic [CNT_W-1:0]     runs_q;
    logic [IDX_W-1:0]     run_idx_q;
    logic [CYC_WIDTH-1:0] cnt_q;
    logic                 busy_q;
    logic                 finished_q;
    logic                 timeout_err_q;
    logic [IDX_W-1:0]     err_run_q;
    logic                 acc_start_q;

    logic [CYC_WIDTH-1:0] cnt_inc;
    logic [CNT_W-1:0]     runs_clamped;
    logic                 last_run;
    logic                 wr_en;

    assign cnt_inc      = cnt_q + CYC_WIDTH'(1);
    assign runs_clamped = (num_runs_i > MAX_RUNS_C) ? MAX_RUNS_C : num_runs_i;
    assign last_run     = (CNT_W'(run_idx_q) + CNT_W'(1)) >= runs_q;
    // The store happens on the very edge that samples done; done outside WAIT is never seen.
    assign wr_en        = (state_q == S_WAIT) && acc.done;

    // cnt_q doubles as the settle counter in SETTLE and the latency/watchdog counter in WAIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            runs_q        <= '0;
            run_idx_q     <= '0;
            cnt_q         <= '0;
            busy_q        <= 1'b0;
            finished_q    <= 1'b0;
            timeout_err_q <= 1'b0;
            err_run_q     <= '0;
            acc_start_q   <= 1'b0;
        end else begin
            acc_start_q <= 1'b0;
            finished_q  <= 1'b0;
            case (state_q)
                S_IDLE, S_ERR: begin
                    if (go_i) begin
                        timeout_err_q <= 1'b0;
                        run_idx_q     <= '0;
                        cnt_q         <= '0;
                        if (num_runs_i == '0) begin
                            finished_q <= 1'b1;
                            state_q    <= S_DONE;
                        end else begin
                            runs_q  <= runs_clamped;
                            busy_q  <= 1'b1;
                            state_q <= S_SETTLE;
                        end
                    end
                end
                S_SETTLE: begin
                    if (cnt_q == SETTLE_LAST) begin
                        if (!acc.busy) begin
                            acc_start_q <= 1'b1;
                            state_q     <= S_START;
                        end
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                S_START: begin
                    cnt_q   <= '0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    cnt_q <= cnt_inc;
                    if (acc.done) begin
                        if (last_run) begin
                            busy_q     <= 1'b0;
                            finished_q <= 1'b1;
                            state_q    <= S_DONE;
                        end else begin
                            run_idx_q <= run_idx_q + IDX_W'(1);
                            cnt_q     <= '0;
                            state_q   <= S_SETTLE;
                        end
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        timeout_err_q <= 1'b1;
                        err_run_q     <= run_idx_q;
                        busy_q        <= 1'b0;
                        state_q       <= S_ERR;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy_o        = busy_q;
    assign finished_o    = finished_q;
    assign timeout_err_o = timeout_err_q;
    assign err_run_o     = err_run_q;
    assign acc.start     = acc_start_q;
    assign acc.img       = run_idx_q;

    lenet_result_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .CYC_WIDTH  (CYC_WIDTH),
        .MAX_RUNS   (MAX_RUNS)
    ) u_buf (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en_i     (wr_en),
        .wr_addr_i   (run_idx_q),
        .wr_result_i (acc.result),
        .wr_cycles_i (cnt_inc),
        .rd_addr_i   (rd_addr_i),
        .rd_result_o (rd_result_o),
        .rd_cycles_o (rd_cycles_o)
    );

endmodule
